// File: rtl/writeback_regfile_pkg.sv
// Shared definitions for the writeback stage and its register file.
//   - datapath / address widths, the hardwired-zero and default link register
//   - result-select encoding and the helper that derives it from W controls
//   - write request struct passed from the top level into the register file
package writeback_regfile_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;
  localparam int NUM_RD_PORTS   = 2;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO         = '0;
  localparam logic [REG_ADDR_WIDTH-1:0] LINK_REG_DEFAULT = 5'd31;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_MEM  = 2'd1,
    RES_LINK = 2'd2
  } res_sel_e;

  typedef struct packed {
    logic                      en;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } wr_req_t;

  // jal outranks the load select: a jal commit always writes the link value.
  function automatic res_sel_e res_sel(input logic jal, input logic mem_to_reg);
    if (jal)             return RES_LINK;
    else if (mem_to_reg) return RES_MEM;
    else                 return RES_ALU;
  endfunction

endpackage

// File: rtl/writeback_regfile_regfile.sv
// regfile_2r1w: 32x32 architectural register file, one write port and
// NUM_RD_PORTS combinational read ports.
//   clk, rst_n : clock, async active-low reset (clears every register)
//   wr         : write request (en/addr/data), committed at the rising edge
//   rd_addr    : per-port read addresses
//   rd_data    : per-port read data, write-first bypassed, $0 reads 0
// rf_rd_port: per-port zero/bypass/array select.
import writeback_regfile_pkg::*;

module rf_rd_port (
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]     arr_data,
  input  logic                      wr_live,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  always_comb begin
    rd_data = arr_data;
    if (rd_addr == REG_ZERO)                 rd_data = '0;
    else if (wr_live && rd_addr == wr_addr)  rd_data = wr_data;
  end

endmodule

module regfile_2r1w #(
  parameter int NUM_RD = NUM_RD_PORTS
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  wr_req_t                                wr,
  input  logic [NUM_RD-1:0][REG_ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]      rd_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  wr_live;

  // Gating with rst_n keeps the bypass from leaking a value onto the read
  // ports while reset holds the array at zero.
  assign wr_live = wr.en && rst_n && (wr.addr != REG_ZERO);

  assign mem[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          mem[r] <= '0;
      else if (wr_live && wr.addr == REG_ADDR_WIDTH'(r))   mem[r] <= wr.data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_rd_port u_rd (
      .rd_addr  (rd_addr[p]),
      .arr_data (mem[rd_addr[p]]),
      .wr_live  (wr_live),
      .wr_addr  (wr.addr),
      .wr_data  (wr.data),
      .rd_data  (rd_data[p])
    );
  end

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: MIPS W stage. Selects the writeback result, commits it
// to the register file (jal forces the link register), serves the decode
// read ports, and keeps the display latch and committed-write counter.
//   Clk, Reset                 : clock, async active-low reset
//   MemtoRegW/RegWriteW/jalW   : W-stage controls
//   MemReadDataW/ALUResultW/
//   PCPlus4W/WriteRegW         : W-stage data and destination
//   DisplayW                   : latch ResultW into DisplayValue
//   ReadReg1D/2D -> ReadData1D/2D : decode reads (combinational, bypassed)
//   ResultW                    : selected result (combinational)
//   DisplayValue/DisplayStrobe : display register and its update pulse
//   WritebackCount             : count of committed register writes (wraps)
import writeback_regfile_pkg::*;

module writeback_regfile #(
  parameter logic [REG_ADDR_WIDTH-1:0] LINK_REG    = LINK_REG_DEFAULT,
  parameter int                        COUNT_WIDTH = 32
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      MemtoRegW,
  input  logic                      RegWriteW,
  input  logic [DATA_WIDTH-1:0]     MemReadDataW,
  input  logic [DATA_WIDTH-1:0]     ALUResultW,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegW,
  input  logic [DATA_WIDTH-1:0]     PCPlus4W,
  input  logic                      jalW,
  input  logic                      DisplayW,
  input  logic [REG_ADDR_WIDTH-1:0] ReadReg1D,
  input  logic [REG_ADDR_WIDTH-1:0] ReadReg2D,
  output logic [DATA_WIDTH-1:0]     ReadData1D,
  output logic [DATA_WIDTH-1:0]     ReadData2D,
  output logic [DATA_WIDTH-1:0]     ResultW,
  output logic [DATA_WIDTH-1:0]     DisplayValue,
  output logic                      DisplayStrobe,
  output logic [COUNT_WIDTH-1:0]    WritebackCount
);

  res_sel_e                                    sel;
  wr_req_t                                     wr;
  logic [NUM_RD_PORTS-1:0][REG_ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]     rd_data;

  assign sel = res_sel(jalW, MemtoRegW);

  always_comb begin
    ResultW = ALUResultW;
    unique case (sel)
      RES_LINK: ResultW = PCPlus4W;
      RES_MEM:  ResultW = MemReadDataW;
      default:  ResultW = ALUResultW;
    endcase
  end

  always_comb begin
    wr.addr = jalW ? LINK_REG : WriteRegW;
    wr.data = ResultW;
    // $0 writes are dropped here so they never reach the counter either.
    wr.en   = (RegWriteW || jalW) && (wr.addr != REG_ZERO);
  end

  assign rd_addr    = {ReadReg2D, ReadReg1D};
  assign ReadData1D = rd_data[0];
  assign ReadData2D = rd_data[1];

  regfile_2r1w #(.NUM_RD(NUM_RD_PORTS)) u_rf (
    .clk     (Clk),
    .rst_n   (Reset),
    .wr      (wr),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Display latch is independent of the write enable.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      DisplayValue  <= '0;
      DisplayStrobe <= 1'b0;
    end else begin
      DisplayStrobe <= DisplayW;
      if (DisplayW) DisplayValue <= ResultW;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)     WritebackCount <= '0;
    else if (wr.en) WritebackCount <= WritebackCount + COUNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MemtoRegW, RegWriteW, jalW, DisplayW;
  logic [31:0] MemReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  WriteRegW, ReadReg1D, ReadReg2D;
  logic [31:0] ReadData1D, ReadData2D, ResultW, DisplayValue;
  logic        DisplayStrobe;
  logic [3:0]  WritebackCount;

  int errors = 0;
  int checks = 0;

  writeback_regfile #(.LINK_REG(5'd31), .COUNT_WIDTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
    .MemReadDataW(MemReadDataW), .ALUResultW(ALUResultW), .WriteRegW(WriteRegW),
    .PCPlus4W(PCPlus4W), .jalW(jalW), .DisplayW(DisplayW),
    .ReadReg1D(ReadReg1D), .ReadReg2D(ReadReg2D),
    .ReadData1D(ReadData1D), .ReadData2D(ReadData2D), .ResultW(ResultW),
    .DisplayValue(DisplayValue), .DisplayStrobe(DisplayStrobe),
    .WritebackCount(WritebackCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_disp   = '0;
  logic        m_strobe = 1'b0;
  int          m_cnt    = 0;

  initial for (int i = 0; i < 32; i++) m_regs[i] = '0;

  function automatic logic [31:0] m_result();
    if (jalW)      return PCPlus4W;
    if (MemtoRegW) return MemReadDataW;
    return ALUResultW;
  endfunction

  function automatic logic [4:0] m_waddr();
    return jalW ? 5'd31 : WriteRegW;
  endfunction

  function automatic logic m_we();
    return Reset === 1'b1 && (RegWriteW || jalW) && m_waddr() != 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0 || Reset !== 1'b1) return '0;
    if (m_we() && a == m_waddr())    return m_result();
    return m_regs[a];
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_disp   <= '0;
      m_strobe <= 1'b0;
      m_cnt    <= 0;
    end else begin
      if (m_we()) begin
        m_regs[m_waddr()] <= m_result();
        m_cnt             <= (m_cnt + 1) % 16;
      end
      m_strobe <= DisplayW;
      if (DisplayW) m_disp <= m_result();
    end
  end

  // Compare process: every falling edge, away from the input-change point.
  always @(negedge Clk) begin
    chk("rd1",    ReadData1D,            m_read(ReadReg1D));
    chk("rd2",    ReadData2D,            m_read(ReadReg2D));
    chk("result", ResultW,               m_result());
    chk("disp",   DisplayValue,          m_disp);
    chk("strobe", {31'd0, DisplayStrobe}, {31'd0, m_strobe});
    chk("count",  {28'd0, WritebackCount}, 32'(m_cnt));
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        rst, rw, m2r, jal, disp;
    logic [31:0] alu, mem, pc4;
    logic [4:0]  wreg, r1, r2;
  } stim_t;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.rw = 1'b0; s.m2r = 1'b0; s.jal = 1'b0; s.disp = 1'b0;
    s.alu = '0; s.mem = '0; s.pc4 = '0; s.wreg = '0; s.r1 = '0; s.r2 = '0;
    return s;
  endfunction

  function automatic stim_t rnd(input logic rst);
    stim_t s;
    s.rst = rst; s.rw = 1'($urandom); s.m2r = 1'($urandom);
    s.jal = ($urandom_range(0, 7) == 0); s.disp = ($urandom_range(0, 3) == 0);
    s.alu = $urandom; s.mem = $urandom; s.pc4 = $urandom;
    s.wreg = 5'($urandom_range(0, 7));
    s.r1 = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    s.r2 = 5'($urandom);
    return s;
  endfunction

  // Apply after the rising edge, then land just past the falling edge.
  task automatic step(input stim_t s);
    @(posedge Clk);
    #2;
    Reset = s.rst; RegWriteW = s.rw; MemtoRegW = s.m2r; jalW = s.jal;
    DisplayW = s.disp; ALUResultW = s.alu; MemReadDataW = s.mem;
    PCPlus4W = s.pc4; WriteRegW = s.wreg; ReadReg1D = s.r1; ReadReg2D = s.r2;
    @(negedge Clk);
    #1;
  endtask

  initial begin
    stim_t s;
    Reset = 1'b1; RegWriteW = 0; MemtoRegW = 0; jalW = 0; DisplayW = 0;
    ALUResultW = 0; MemReadDataW = 0; PCPlus4W = 0; WriteRegW = 0;
    ReadReg1D = 0; ReadReg2D = 0;
    #1 Reset = 1'b0;

    // reset held low with busy inputs
    repeat (3) begin
      step(rnd(1'b0));
      chk("rst_rd1", ReadData1D, 32'h0);
      chk("rst_rd2", ReadData2D, 32'h0);
      chk("rst_disp", DisplayValue, 32'h0);
      chk("rst_strobe", {31'd0, DisplayStrobe}, 32'h0);
      chk("rst_count", {28'd0, WritebackCount}, 32'h0);
    end
    step(idle());

    // write $5 with bypass, then read from the array
    s = idle(); s.rw = 1; s.wreg = 5; s.alu = 32'h1234; s.r1 = 5;
    step(s);
    chk("bypass_r5", ReadData1D, 32'h1234);
    s = idle(); s.r1 = 5;
    step(s);
    chk("array_r5", ReadData1D, 32'h1234);
    chk("count_1", {28'd0, WritebackCount}, 32'd1);

    // $0 write is dropped
    s = idle(); s.m2r = 1; s.mem = 32'hDEADBEEF; s.rw = 1; s.wreg = 0;
    step(s);
    chk("r0_read", ReadData1D, 32'h0);
    chk("mem_result", ResultW, 32'hDEADBEEF);
    step(idle());
    chk("count_r0", {28'd0, WritebackCount}, 32'd1);

    // jal writes $31, not WriteRegW
    s = idle(); s.rw = 1; s.wreg = 7; s.alu = 32'h77;
    step(s);
    s = idle(); s.jal = 1; s.pc4 = 32'h00400010; s.wreg = 7; s.alu = 32'h99;
    s.r1 = 31; s.r2 = 7;
    step(s);
    chk("jal_bypass31", ReadData1D, 32'h00400010);
    chk("jal_r7_keep", ReadData2D, 32'h77);
    chk("jal_result", ResultW, 32'h00400010);
    s = idle(); s.r1 = 31; s.r2 = 7;
    step(s);
    chk("jal_r31", ReadData1D, 32'h00400010);
    chk("jal_r7", ReadData2D, 32'h77);
    chk("count_3", {28'd0, WritebackCount}, 32'd3);

    // display latch and one-cycle strobe
    s = idle(); s.disp = 1; s.alu = 32'hCAFE;
    step(s);
    chk("disp_pre_strobe", {31'd0, DisplayStrobe}, 32'h0);
    step(idle());
    chk("disp_val", DisplayValue, 32'hCAFE);
    chk("disp_strobe", {31'd0, DisplayStrobe}, 32'h1);
    step(idle());
    chk("disp_strobe_off", {31'd0, DisplayStrobe}, 32'h0);
    chk("disp_hold", DisplayValue, 32'hCAFE);
    chk("count_disp", {28'd0, WritebackCount}, 32'd3);

    // both ports bypass the same target
    s = idle(); s.rw = 1; s.wreg = 9; s.alu = 32'hA5A5; s.r1 = 9; s.r2 = 9;
    step(s);
    chk("dual_rd1", ReadData1D, 32'hA5A5);
    chk("dual_rd2", ReadData2D, 32'hA5A5);

    // back-to-back writes to $10: last wins, both count
    s = idle(); s.rw = 1; s.wreg = 10; s.alu = 32'h1;
    step(s);
    s.alu = 32'h2; s.r1 = 10;
    step(s);
    chk("b2b_bypass", ReadData1D, 32'h2);
    s = idle(); s.r1 = 10;
    step(s);
    chk("b2b_array", ReadData1D, 32'h2);
    chk("count_6", {28'd0, WritebackCount}, 32'd6);

    // counter wrap at width 4
    for (int i = 0; i < 9; i++) begin
      s = idle(); s.rw = 1; s.wreg = 12; s.alu = 32'(i);
      step(s);
    end
    step(idle());
    chk("count_15", {28'd0, WritebackCount}, 32'd15);
    s = idle(); s.rw = 1; s.wreg = 13; s.alu = 32'h5;
    step(s);
    step(idle());
    chk("count_wrap", {28'd0, WritebackCount}, 32'd0);

    // reset mid-write discards the write
    s = idle(); s.rw = 1; s.wreg = 20; s.alu = 32'hBAD; s.r1 = 20;
    step(s);
    chk("pre_rst_bypass", ReadData1D, 32'hBAD);
    Reset = 1'b0;
    #1;
    chk("rst_mid_rd", ReadData1D, 32'h0);
    s = idle(); s.r1 = 20; s.r2 = 5;
    step(s);
    chk("rst_r20", ReadData1D, 32'h0);
    chk("rst_r5", ReadData2D, 32'h0);
    chk("rst_disp_clr", DisplayValue, 32'h0);
    chk("rst_count_clr", {28'd0, WritebackCount}, 32'h0);

    // mixed traffic, model compare only
    for (int i = 0; i < 300; i++) step(rnd($urandom_range(0, 40) != 0));
    step(idle());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and architectural register file for the pipelined MIPS core; the consumer of the MEM/WB pipeline register's W-stage outputs. It selects the writeback result, commits it to a 32×32 register file, and serves the decode stage's two read ports with write-first bypass. It also holds the display latch and a committed-writeback counter.

## Interface
Parameters:
- LINK_REG, 31, destination register forced by jal
- COUNT_WIDTH, 32, width of WritebackCount

Ports:
- Clk  in  1  pipeline clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset
- MemtoRegW  in  1  select MemReadDataW over ALUResultW
- RegWriteW  in  1  register write request
- MemReadDataW  in  32  load data from the MEM/WB register
- ALUResultW  in  32  ALU result from the MEM/WB register
- WriteRegW  in  5  destination register
- PCPlus4W  in  32  link value for jal
- jalW  in  1  jal commit: write PCPlus4W to LINK_REG
- DisplayW  in  1  latch the result into the display register
- ReadReg1D  in  5  decode read address, port 1
- ReadReg2D  in  5  decode read address, port 2
- ReadData1D  out  32  read data, port 1 (combinational)
- ReadData2D  out  32  read data, port 2 (combinational)
- ResultW  out  32  selected writeback value (combinational, for forwarding)
- DisplayValue  out  32  registered display value
- DisplayStrobe  out  1  one-cycle pulse when DisplayValue updates
- WritebackCount  out  COUNT_WIDTH  number of committed register writes

## Operation
- Result select: jalW → PCPlus4W; else MemtoRegW → MemReadDataW; else ALUResultW.
- Write address: jalW → LINK_REG; else WriteRegW.
- Write enable WE: (RegWriteW | jalW) and write address ≠ 0. Writes to $0 are dropped silently.
- Register array: written at the rising edge when WE = 1.
- Read ports: address 0 returns 0. If WE = 1 and the read address equals the write address, the port returns ResultW (write-first bypass). Otherwise the port returns the array contents.
- Both read ports may hit the same register or the write target in the same cycle. Each port bypasses independently.
- Display: when DisplayW = 1, DisplayValue ← ResultW and DisplayStrobe ← 1 at the edge. Otherwise DisplayValue holds and DisplayStrobe ← 0. DisplayW does not depend on WE.
- Counter: WritebackCount increments by 1 at each edge with WE = 1 and wraps from all-ones to 0. Dropped $0 writes and bubbles (all controls 0) do not count.
- Reset asserted (low):
  - All 32 registers, DisplayValue, DisplayStrobe and WritebackCount clear to 0 immediately.
  - Writes are inhibited while Reset is low.
  - Read ports still operate combinationally and return 0.
  - Reset mid-stream discards any in-flight write at that edge.
- Reset deassertion: the first edge with Reset high behaves as a normal cycle.

## Timing
- Write latency: the value is in the array one edge after WE. It is visible on the read ports in the same cycle through bypass.
- DisplayValue and DisplayStrobe: one-cycle latency from DisplayW.
- WritebackCount: updates at the edge of the qualifying cycle.
- ReadData1D, ReadData2D and ResultW are purely combinational; no registers in these paths.
- Back-to-back writes to the same register: the last one wins. Each write counts.
- Reset: asynchronous assertion; release is sampled at the next rising Clk.

## Structure
- Shared package holds:
  - REG_ZERO = 0
  - LINK_REG default = 31
  - DATA_WIDTH = 32
  - REG_ADDR_WIDTH = 5
  - the result-select encoding (ALU, MEM, LINK)
- Sub-module regfile_2r1w: the array, the $0 hardwiring, write-first bypass and async reset.
- Top level holds: result mux, link address override, display latch and counter.

## Test plan
- Reset low with random inputs → all read ports 0, DisplayValue 0, DisplayStrobe 0, WritebackCount 0.
- RegWriteW=1, WriteRegW=5, ALUResultW=0x1234, MemtoRegW=0, ReadReg1D=5 → ReadData1D=0x1234 the same cycle (bypass). Next cycle with RegWriteW=0 → still 0x1234; WritebackCount=1.
- MemtoRegW=1, MemReadDataW=0xDEADBEEF, RegWriteW=1, WriteRegW=0 → $0 reads 0 and WritebackCount is unchanged.
- jalW=1, PCPlus4W=0x00400010, WriteRegW=7 → $31=0x00400010 and $7 is unchanged.
- DisplayW=1, ALUResultW=0xCAFE, RegWriteW=0 → next cycle DisplayValue=0xCAFE and DisplayStrobe=1. The following cycle DisplayStrobe=0.
- Preload WritebackCount to all-ones via 2^32-1 writes (or COUNT_WIDTH=4 with 15 writes), then one more write → count=0. Reset pulsed mid-write → the write is discarded and the register reads 0.
